// File: rtl/ets_axil_reader.sv
// AXI4-Lite burst read master: fetches word_count consecutive 32-bit words from
// base_addr, one outstanding read at a time, and forwards them on a ready/valid stream.
module ets_axil_reader #(
  parameter int S_AXI_ADDR_WIDTH = 11,
  parameter int S_AXI_DATA_WIDTH = 32,
  parameter int CNT_WIDTH        = 10
) (
  input  logic                        S_AXI_DATA_aclk,
  input  logic                        S_AXI_DATA_aresetn,

  input  logic                        start,
  input  logic [S_AXI_ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]        word_count,
  output logic                        busy,
  output logic                        done,
  output logic                        err,

  output logic [S_AXI_ADDR_WIDTH-1:0] M_AXI_DATA_araddr,
  output logic [2:0]                  M_AXI_DATA_arprot,
  output logic                        M_AXI_DATA_arvalid,
  input  logic                        M_AXI_DATA_arready,
  input  logic [S_AXI_DATA_WIDTH-1:0] M_AXI_DATA_rdata,
  input  logic [1:0]                  M_AXI_DATA_rresp,
  input  logic                        M_AXI_DATA_rvalid,
  output logic                        M_AXI_DATA_rready,

  output logic [S_AXI_DATA_WIDTH-1:0] out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last
);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, PUSH, FIN} state_t;

  state_t                      state;
  state_t                      state_next;
  logic [CNT_WIDTH-1:0]        count_q;
  logic [CNT_WIDTH-1:0]        index_q;
  logic [S_AXI_ADDR_WIDTH-1:0] addr_q;
  logic [S_AXI_DATA_WIDTH-1:0] data_q;
  logic                        err_q;

  logic start_seen;
  logic accept;
  logic ar_hs;
  logic r_hs;
  logic out_hs;
  logic last_word;

  assign start_seen = (state == IDLE) && start;
  assign accept     = start_seen && (word_count != '0);
  assign ar_hs      = (state == ADDR) && M_AXI_DATA_arready;
  assign r_hs       = (state == DATA) && M_AXI_DATA_rvalid;
  assign out_hs     = (state == PUSH) && out_ready;
  assign last_word  = (index_q == (count_q - CNT_WIDTH'(1)));

  always_ff @(posedge S_AXI_DATA_aclk or negedge S_AXI_DATA_aresetn) begin
    if (!S_AXI_DATA_aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = ADDR;
        end else if (start_seen) begin
          state_next = FIN;
        end
      end
      ADDR: if (ar_hs) state_next = DATA;
      DATA: if (r_hs) state_next = PUSH;
      PUSH: begin
        if (out_hs) begin
          state_next = last_word ? FIN : ADDR;
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The address register advances by one word per delivered beat, which keeps it
  // equal to base + 4*index and lets it wrap naturally at the address width.
  always_ff @(posedge S_AXI_DATA_aclk or negedge S_AXI_DATA_aresetn) begin
    if (!S_AXI_DATA_aresetn) begin
      count_q <= '0;
      index_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      if (start_seen) begin
        err_q <= 1'b0;
      end
      if (accept) begin
        addr_q  <= base_addr & ~S_AXI_ADDR_WIDTH'(3);
        count_q <= word_count;
        index_q <= '0;
      end
      if (r_hs) begin
        data_q <= M_AXI_DATA_rdata;
        if (M_AXI_DATA_rresp != 2'b00) begin
          err_q <= 1'b1;
        end
      end
      if (out_hs && !last_word) begin
        index_q <= index_q + CNT_WIDTH'(1);
        addr_q  <= addr_q + S_AXI_ADDR_WIDTH'(4);
      end
    end
  end

  assign M_AXI_DATA_araddr  = addr_q;
  assign M_AXI_DATA_arprot  = 3'b000;
  assign M_AXI_DATA_arvalid = (state == ADDR);
  assign M_AXI_DATA_rready  = (state == DATA);

  assign out_data  = data_q;
  assign out_valid = (state == PUSH);
  assign out_last  = (state == PUSH) && last_word;

  assign busy = (state != IDLE);
  assign done = (state == FIN);
  assign err  = err_q;

endmodule
